// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package fifo_uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_DATA    = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY  = 3'd5,
`endif
        ST_STOP    = 3'd6
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last cycle of every CLKS_PER_BIT period.
// While clear is high the counter is held at zero and no tick is produced.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        // NOTE: a default assignment first keeps this block free of inferred latches.
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO consumer: pops one byte at a time and sends it as an 8N1/8N2 UART frame.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_read,
    input  logic [7:0] fifo_dataout,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t             state_d, state_q;
    logic [2:0]            bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_d, shift_q;
    logic                  baud_clear;
    logic                  bit_tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_d, parity_q;
`endif

    // The baud counter only runs once the line leaves idle, so START always gets a full period.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_CAPTURE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                shift_d   = fifo_dataout;
                bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_dataout;
`endif
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // bit_cnt is reused to count stop-bit periods.
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Outputs decode straight from flops, so an asynchronous reset forces the line high at once.
    always_comb begin
        tx = IDLE_LEVEL;
        unique case (state_q)
            ST_START:  tx = START_LEVEL;
            ST_DATA:   tx = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            default:   tx = IDLE_LEVEL;
        endcase
    end

    assign fifo_read = (state_q == ST_POP);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 32-deep registered-read FIFO.
// Build with FIFO_UART_TX_PARITY_EN defined to exercise the parity frame (STOP_BITS=2).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + 8 + PB + SB;
    localparam int FRAME = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] fifo_dataout;
    logic       tx;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int read_cnt = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_read    (fifo_read),
        .fifo_dataout (fifo_dataout),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fifo_read) begin
            fifo_dataout <= mem[rd_ptr % 32];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    always @(negedge clock) begin
        if (reset_n && fifo_read) read_cnt = read_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 32] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits for a fifo_read pulse at a negedge; returns with the bench sitting in the POP cycle.
    task automatic wait_read(input string name, output bit ok, output int at_cyc);
        ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (fifo_read === 1'b1) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: fifo_read pulse actual=none required=pulse within 300 cycles", name);
        end
    endtask

    // Called in the POP cycle; checks CAPTURE, every line bit, then the following idle cycle.
    task automatic check_frame(input logic [7:0] b, input string name, input int drop_en_bit);
        logic exp;
        logic got;
        bit   err;
        bit   busy_err;
        logic [7:0] d;
        d = b;
        busy_err = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL %s capture_tx: actual=%b required=1", name, tx);
        end
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                  exp = 1'b0;
            else if (k <= 8)             exp = d[k-1];
            else if (PB == 1 && k == 9)  exp = ^d;
            else                         exp = 1'b1;
            err = 1'b0;
            got = exp;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (k == drop_en_bit && c == 0) enable = 1'b0;
                if (tx !== exp) begin
                    err = 1'b1;
                    got = tx;
                end
                if (busy !== 1'b1) busy_err = 1'b1;
            end
            n_cmp++;
            if (err) begin
                n_bad++;
                $display("FAIL %s line_bit%0d: actual=%b required=%b", name, k, got, exp);
            end
        end
        n_cmp++;
        if (busy_err) begin
            n_bad++;
            $display("FAIL %s busy_in_frame: actual=0 required=1", name);
        end
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_bad++;
            $display("FAIL %s after_frame: actual busy=%b tx=%b required busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic test_reset;
        bit tx_err;
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: actual=%b required=1", tx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: actual=%b required=0", busy); end
        n_cmp++;
        if (fifo_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: actual=%b required=0", fifo_read); end
        reset_n = 1'b1;
        tx_err = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1) tx_err = 1'b1;
        end
        n_cmp++;
        if (read_cnt !== 0) begin n_bad++; $display("FAIL empty_no_read: actual=%0d reads required=0", read_cnt); end
        n_cmp++;
        if (tx_err) begin n_bad++; $display("FAIL empty_tx_idle: actual=low seen required=1"); end
    endtask

    task automatic test_single;
        bit ok;
        int at;
        int r0;
        r0 = read_cnt;
        push(8'hA5);
        wait_read("single", ok, at);
        if (ok) check_frame(8'hA5, "single", -1);
        n_cmp++;
        if (read_cnt - r0 !== 1) begin n_bad++; $display("FAIL single_reads: actual=%0d required=1", read_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        bit ok0, ok1;
        int at0, at1;
        push(8'h00);
        push(8'hFF);
        wait_read("b2b_0", ok0, at0);
        if (ok0) check_frame(8'h00, "b2b_0", -1);
        wait_read("b2b_1", ok1, at1);
        if (ok1) check_frame(8'hFF, "b2b_1", -1);
        n_cmp++;
        if (at1 - at0 !== FRAME + 3) begin
            n_bad++;
            $display("FAIL b2b_gap: actual=%0d required=%0d", at1 - at0, FRAME + 3);
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int at;
        int r0;
        push(8'h3C);
        push(8'h81);
        wait_read("endrop_0", ok, at);
        // Drop enable during data bit 2 (line bit index 3).
        if (ok) check_frame(8'h3C, "endrop_0", 3);
        r0 = read_cnt;
        repeat (20) @(negedge clock);
        n_cmp++;
        if (read_cnt !== r0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL endrop_hold: actual reads=%0d busy=%b required reads=%0d busy=0", read_cnt, busy, r0);
        end
        enable = 1'b1;
        wait_read("endrop_1", ok, at);
        if (ok) check_frame(8'h81, "endrop_1", -1);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int at;
        push(8'h55);
        push(8'h66);
        wait_read("rstmid_0", ok, at);
        // POP, CAPTURE, START (4), data bits 0..2 (12), then one cycle into bit 3.
        repeat (1 + CPB + 3 * CPB + 1) @(negedge clock);
        n_cmp++;
        if (tx !== 1'b0) begin n_bad++; $display("FAIL rstmid_bit3: actual=%b required=0", tx); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: actual tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_read("rstmid_1", ok, at);
        if (ok) check_frame(8'h66, "rstmid_1", -1);
        n_cmp++;
        if (rd_ptr !== wr_ptr) begin
            n_bad++;
            $display("FAIL rstmid_ptrs: actual rd=%0d required=%0d", rd_ptr, wr_ptr);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        bit ok0, ok1;
        int at0, at1;
        push(8'h07);
        push(8'hA5);
        wait_read("par_07", ok0, at0);
        if (ok0) check_frame(8'h07, "par_07", -1);
        wait_read("par_a5", ok1, at1);
        if (ok1) check_frame(8'hA5, "par_a5", -1);
        n_cmp++;
        if (at1 - at0 !== 51) begin
            n_bad++;
            $display("FAIL par_gap: actual=%0d required=51", at1 - at0);
        end
    endtask
`endif

    initial begin
        fifo_dataout = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_enable_drop;
        test_reset_mid;
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
